// File: rtl/alarm_bank_m_pkg.sv
// alarm_bank_m_pkg -- shared types and constants for the alarm bank.
//   COUNTER_W / COUNTER_MAX : default timestamp width and last valid timestamp
//   COUNTER_T / FLAG_T      : timestamp and single-bit flag types
//   chan_state_e            : per-channel alarm FSM state
package alarm_bank_m_pkg;

   localparam int COUNTER_W   = 17;
   localparam int COUNTER_MAX = 86399;

   typedef logic [COUNTER_W-1:0] COUNTER_T;
   typedef logic                 FLAG_T;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_RINGING  = 2'd2,
      ST_SNOOZED  = 2'd3
   } chan_state_e;

endpackage

// File: rtl/alarm_bank_m_chan.sv
// alarm_chan_m -- one alarm channel: DISABLED/ARMED/RINGING/SNOOZED FSM.
//   clock, reset_n        : clock, async active-low reset
//   tick, counter_state   : once-per-second strobe and current timestamp
//   cfg_ld, cfg_time/en   : validated configuration load for this channel
//   dismiss, snooze       : level inputs, sampled every cycle
//   ringing/snoozed       : decoded from the state register
//   missed                : sticky, set when ringing times out
module alarm_chan_m
   import alarm_bank_m_pkg::*;
#(
   parameter int CW           = COUNTER_W,
   parameter int SNOOZE_SEC   = 540,
   parameter int RING_TIMEOUT = 3600
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          tick,
   input  logic [CW-1:0] counter_state,
   input  logic          cfg_ld,
   input  logic [CW-1:0] cfg_time,
   input  logic          cfg_en,
   input  logic          dismiss,
   input  logic          snooze,
   output logic          ringing,
   output logic          snoozed,
   output logic          missed
);

   localparam int RW = $clog2(RING_TIMEOUT + 1);
   localparam int SW = $clog2(SNOOZE_SEC + 1);
   localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT - 1);
   localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SEC);

   chan_state_e   r_state,  w_state;
   logic [CW-1:0] r_time,   w_time;
   logic [RW-1:0] r_ring,   w_ring;
   logic [SW-1:0] r_snz,    w_snz;
   logic          r_missed, w_missed;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_DISABLED;
         r_time   <= '0;
         r_ring   <= '0;
         r_snz    <= '0;
         r_missed <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_time   <= w_time;
         r_ring   <= w_ring;
         r_snz    <= w_snz;
         r_missed <= w_missed;
      end
   end

   // Priority: cfg load, dismiss, snooze, tick event.
   always_comb begin
      w_state  = r_state;
      w_time   = r_time;
      w_ring   = r_ring;
      w_snz    = r_snz;
      w_missed = r_missed;
      if (cfg_ld) begin
         w_time   = cfg_time;
         w_missed = 1'b0;
         w_state  = cfg_en ? ST_ARMED : ST_DISABLED;
         w_ring   = '0;
         w_snz    = '0;
      end else begin
         case (r_state)
            ST_ARMED: begin
               if (tick && (counter_state == r_time)) begin
                  w_state = ST_RINGING;
                  w_ring  = '0;
               end
            end
            ST_RINGING: begin
               if (dismiss) begin
                  w_state = ST_ARMED;
               end else if (snooze) begin
                  w_state = ST_SNOOZED;
                  w_snz   = SNZ_LOAD;
               end else if (tick) begin
                  // Count reaches RING_TIMEOUT-1 after that many ticks; the next one times out.
                  if (r_ring >= RING_LAST) begin
                     w_state  = ST_ARMED;
                     w_missed = 1'b1;
                     w_ring   = '0;
                  end else begin
                     w_ring = r_ring + RW'(1);
                  end
               end
            end
            ST_SNOOZED: begin
               if (dismiss) begin
                  w_state = ST_ARMED;
                  w_snz   = '0;
               end else if (tick) begin
                  if (r_snz <= SW'(1)) begin
                     w_state = ST_RINGING;
                     w_ring  = '0;
                     w_snz   = '0;
                  end else begin
                     w_snz = r_snz - SW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign ringing = (r_state == ST_RINGING);
   assign snoozed = (r_state == ST_SNOOZED);
   assign missed  = r_missed;

endmodule

// File: rtl/alarm_bank_m.sv
// alarm_bank_m -- bank of CHANNELS independent alarm channels.
//   clock, reset_n          : clock, async active-low reset
//   tick, counter_state     : once-per-second strobe and current timestamp
//   cfg_wr/ch/time/en       : configuration write; rejected if time or channel out of range
//   dismiss, snooze         : per-channel level inputs
//   ringing, snoozed, missed: per-channel status
//   alarm_any               : OR of ringing
//   cfg_err                 : one-cycle pulse after a rejected cfg_wr
module alarm_bank_m
   import alarm_bank_m_pkg::*;
#(
   parameter int CHANNELS     = 4,
   parameter int COUNTER_MAX  = alarm_bank_m_pkg::COUNTER_MAX,
   parameter int CW           = COUNTER_W,
   parameter int SNOOZE_SEC   = 540,
   parameter int RING_TIMEOUT = 3600,
   localparam int CHW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                tick,
   input  logic [CW-1:0]       counter_state,
   input  logic                cfg_wr,
   input  logic [CHW-1:0]      cfg_ch,
   input  logic [CW-1:0]       cfg_time,
   input  logic                cfg_en,
   input  logic [CHANNELS-1:0] dismiss,
   input  logic [CHANNELS-1:0] snooze,
   output logic [CHANNELS-1:0] ringing,
   output logic [CHANNELS-1:0] snoozed,
   output logic [CHANNELS-1:0] missed,
   output logic                alarm_any,
   output logic                cfg_err
);

   localparam logic [CW-1:0] MAX_C = CW'(COUNTER_MAX);

   logic  w_cfg_ok;
   FLAG_T r_cfg_err;

   assign w_cfg_ok = (cfg_time <= MAX_C) && (int'(cfg_ch) < CHANNELS);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_cfg_err <= 1'b0;
      else          r_cfg_err <= cfg_wr && !w_cfg_ok;
   end

   assign cfg_err   = r_cfg_err;
   assign alarm_any = |ringing;

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic w_ld;
      assign w_ld = cfg_wr && w_cfg_ok && (int'(cfg_ch) == gi);

      alarm_chan_m #(
         .CW           (CW),
         .SNOOZE_SEC   (SNOOZE_SEC),
         .RING_TIMEOUT (RING_TIMEOUT)
      ) u_chan (
         .clock         (clock),
         .reset_n       (reset_n),
         .tick          (tick),
         .counter_state (counter_state),
         .cfg_ld        (w_ld),
         .cfg_time      (cfg_time),
         .cfg_en        (cfg_en),
         .dismiss       (dismiss[gi]),
         .snooze        (snooze[gi]),
         .ringing       (ringing[gi]),
         .snoozed       (snoozed[gi]),
         .missed        (missed[gi])
      );
   end

endmodule

// File: tb/tb_alarm_bank_m.sv
// tb_alarm_bank_m -- directed bench for alarm_bank_m with hand-computed expectations.
// A second 3-channel instance covers rejection of an out-of-range channel index.
module tb_alarm_bank_m;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        tick;
   logic [16:0] counter_state;
   logic        cfg_wr;
   logic [1:0]  cfg_ch;
   logic [16:0] cfg_time;
   logic        cfg_en;
   logic [3:0]  dismiss;
   logic [3:0]  snooze;
   logic [3:0]  ringing, snoozed, missed;
   logic        alarm_any, cfg_err;

   logic        cfg_wr3;
   logic [1:0]  cfg_ch3;
   logic [16:0] cfg_time3;
   logic        cfg_en3;
   logic [2:0]  ringing3, snoozed3, missed3;
   logic        alarm_any3, cfg_err3;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   alarm_bank_m dut (
      .clock(clock), .reset_n(reset_n), .tick(tick), .counter_state(counter_state),
      .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_time(cfg_time), .cfg_en(cfg_en),
      .dismiss(dismiss), .snooze(snooze), .ringing(ringing), .snoozed(snoozed),
      .missed(missed), .alarm_any(alarm_any), .cfg_err(cfg_err)
   );

   alarm_bank_m #(.CHANNELS(3)) dut3 (
      .clock(clock), .reset_n(reset_n), .tick(tick), .counter_state(counter_state),
      .cfg_wr(cfg_wr3), .cfg_ch(cfg_ch3), .cfg_time(cfg_time3), .cfg_en(cfg_en3),
      .dismiss(dismiss[2:0]), .snooze(snooze[2:0]), .ringing(ringing3), .snoozed(snoozed3),
      .missed(missed3), .alarm_any(alarm_any3), .cfg_err(cfg_err3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic cfg(input int ch, input int t, input logic en);
      cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_time = 17'(t); cfg_en = en;
      step();
      cfg_wr = 1'b0;
   endtask

   task automatic ticks(input int n, input int ts);
      tick = 1'b1; counter_state = 17'(ts);
      repeat (n) step();
      tick = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; tick = 1'b0; counter_state = '0;
      cfg_wr = 1'b0; cfg_ch = '0; cfg_time = '0; cfg_en = 1'b0;
      dismiss = '0; snooze = '0;
      cfg_wr3 = 1'b0; cfg_ch3 = '0; cfg_time3 = '0; cfg_en3 = 1'b0;
      step(); step();
      chk("rst_ringing", 32'(ringing), 32'h0);
      chk("rst_snoozed", 32'(snoozed), 32'h0);
      chk("rst_missed",  32'(missed),  32'h0);
      chk("rst_any",     32'(alarm_any), 32'h0);
      chk("rst_cfg_err", 32'(cfg_err), 32'h0);
      reset_n = 1'b1;
      step();

      // ch1 fires at 25200, only on a tick
      cfg(1, 25200, 1'b1);
      chk("cfg_ok_no_err", 32'(cfg_err), 32'h0);
      ticks(1, 25199);
      chk("ch1_early", 32'(ringing), 32'h0);
      counter_state = 17'd25200; step();
      chk("ch1_no_tick_eq", 32'(ringing), 32'h0);
      ticks(1, 25200);
      chk("ch1_ring", 32'(ringing), 32'h2);
      chk("ch1_any",  32'(alarm_any), 32'h1);
      dismiss = 4'b0010; step(); dismiss = '0;
      chk("ch1_dismiss", 32'(ringing), 32'h0);
      chk("ch1_dismiss_missed", 32'(missed), 32'h0);

      // ch0 at time 0 (rollover value), snooze for 540 ticks
      cfg(0, 0, 1'b1);
      ticks(1, 0);
      chk("ch0_ring_t0", 32'(ringing), 32'h1);
      snooze = 4'b0001; step(); snooze = '0;
      chk("ch0_snoozed", 32'(snoozed), 32'h1);
      chk("ch0_snz_ring", 32'(ringing), 32'h0);
      ticks(539, 100);
      chk("ch0_snz_539", 32'(snoozed), 32'h1);
      chk("ch0_snz_539_ring", 32'(ringing), 32'h0);
      ticks(1, 100);
      chk("ch0_rering", 32'(ringing), 32'h1);
      chk("ch0_rering_snz", 32'(snoozed), 32'h0);
      dismiss = 4'b0001; step(); dismiss = '0;
      chk("ch0_dismiss", 32'(ringing), 32'h0);

      // ch2 rings unanswered for 3600 ticks
      cfg(2, 500, 1'b1);
      ticks(1, 500);
      chk("ch2_ring", 32'(ringing), 32'h4);
      ticks(3599, 501);
      chk("ch2_ring_3599", 32'(ringing), 32'h4);
      chk("ch2_missed_3599", 32'(missed), 32'h0);
      ticks(1, 501);
      chk("ch2_timeout_ring", 32'(ringing), 32'h0);
      chk("ch2_timeout_missed", 32'(missed), 32'h4);
      ticks(1, 500);
      chk("ch2_rearmed", 32'(ringing), 32'h4);
      dismiss = 4'b0100; step(); dismiss = '0;
      chk("ch2_dismiss_keeps_missed", 32'(missed), 32'h4);
      cfg(2, 500, 1'b0);
      chk("ch2_cfg_clears_missed", 32'(missed), 32'h0);
      ticks(1, 500);
      chk("ch2_disabled", 32'(ringing), 32'h0);

      // out-of-range time: error pulse, no state change
      cfg(1, 86400, 1'b1);
      chk("bad_time_err", 32'(cfg_err), 32'h1);
      step();
      chk("bad_time_err_once", 32'(cfg_err), 32'h0);
      ticks(1, 86400);
      chk("bad_time_no_match", 32'(ringing), 32'h0);
      ticks(1, 25200);
      chk("bad_time_ch1_kept", 32'(ringing), 32'h2);
      dismiss = 4'b0010; step(); dismiss = '0;

      // out-of-range channel on the 3-channel instance
      cfg_wr3 = 1'b1; cfg_ch3 = 2'd3; cfg_time3 = 17'd7; cfg_en3 = 1'b1;
      step(); cfg_wr3 = 1'b0;
      chk("bad_ch_err", 32'(cfg_err3), 32'h1);
      step();
      chk("bad_ch_err_once", 32'(cfg_err3), 32'h0);
      ticks(1, 7);
      chk("bad_ch_no_load", 32'(ringing3), 32'h0);
      cfg_wr3 = 1'b1; cfg_ch3 = 2'd2;
      step(); cfg_wr3 = 1'b0;
      chk("ch3x_ok_no_err", 32'(cfg_err3), 32'h0);
      ticks(1, 7);
      chk("ch3x_ring", 32'(ringing3), 32'h4);

      // dismiss beats snooze on ch3
      cfg(3, 1000, 1'b1);
      ticks(1, 1000);
      chk("ch3_ring", 32'(ringing), 32'h8);
      dismiss = 4'b1000; snooze = 4'b1000; step(); dismiss = '0; snooze = '0;
      chk("ch3_dis_snz_ring", 32'(ringing), 32'h0);
      chk("ch3_dis_snz_snoozed", 32'(snoozed), 32'h0);
      ticks(1, 1000);
      chk("ch3_armed_again", 32'(ringing), 32'h8);
      snooze = 4'b1000; step(); snooze = '0;
      chk("ch3_snoozed", 32'(snoozed), 32'h8);
      ticks(1, 0);
      chk("mid_ch0_ring", 32'(ringing), 32'h1);

      // async reset mid-ring/mid-snooze
      reset_n = 1'b0; #1;
      chk("arst_ringing", 32'(ringing), 32'h0);
      chk("arst_snoozed", 32'(snoozed), 32'h0);
      chk("arst_any",     32'(alarm_any), 32'h0);
      chk("arst_ringing3", 32'(ringing3), 32'h0);
      step();
      reset_n = 1'b1;
      step();
      ticks(1, 0);
      chk("post_rst_t0", 32'(ringing), 32'h0);
      ticks(1, 1000);
      chk("post_rst_t1000", 32'(ringing), 32'h0);
      ticks(540, 5);
      chk("post_rst_snz", 32'(ringing), 32'h0);

      // cfg_wr beats dismiss on the same channel
      cfg(3, 1000, 1'b1);
      ticks(1, 1000);
      snooze = 4'b1000; step(); snooze = '0;
      chk("prio_snoozed", 32'(snoozed), 32'h8);
      dismiss = 4'b1000;
      cfg(3, 1000, 1'b0);
      dismiss = '0;
      chk("prio_cfg_snz", 32'(snoozed), 32'h0);
      ticks(1, 1000);
      chk("prio_cfg_disabled", 32'(ringing), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
